memory_bus_arbiter: RTL

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter_if.sv | 53 +++++
 rtl/memory_bus_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter_if.sv
// Bundle of the two requester ports and the memory_controller port of memory_bus_arbiter.
// The arbiter side uses modport slave; requesters and the memory model use modport master.
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 8
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 8
`endif

interface memory_bus_arbiter_if #(
  parameter int ADDR_W = `MEMORY_DEPTH,
  parameter int DATA_W = `MEMORY_WIDTH
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] memory_read_address;
  logic [DATA_W-1:0] memory_read_data;
  logic [ADDR_W-1:0] memory_write_address;
  logic [DATA_W-1:0] memory_write_data;
  logic              memory_write_enable;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  memory_read_data,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output memory_read_address, memory_write_address, memory_write_data, memory_write_enable
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output memory_read_data,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  memory_read_address, memory_write_address, memory_write_data, memory_write_enable
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Two-requester arbiter in front of a single-port memory_controller, one access in flight.
// Define MEMORY_BUS_ARBITER_RR_EN for round-robin tie-breaking; otherwise requester 0 always wins.
`ifndef MEMORY_DEPTH
`define MEMORY_DEPTH 8
`endif
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 8
`endif

module memory_bus_arbiter #(
  parameter int ADDR_W = `MEMORY_DEPTH,
  parameter int DATA_W = `MEMORY_WIDTH,
  parameter int RD_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  memory_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;

  state_t            state, state_nxt;
  logic              cur_we, cur_we_nxt;
  logic              cur_id, cur_id_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [1:0]        gnt, gnt_nxt;
  logic [1:0]        rvalid, rvalid_nxt;
  logic [DATA_W-1:0] rdata0, rdata0_nxt;
  logic [DATA_W-1:0] rdata1, rdata1_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [DATA_W-1:0] wr_data, wr_data_nxt;
  logic              wr_en, wr_en_nxt;

  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MEMORY_BUS_ARBITER_RR_EN
  // prio names the requester that wins the next tie; it flips away from every grantee.
  logic prio, prio_nxt;
  assign win = bus.m1_req & (~bus.m0_req | prio);
`else
  assign win = bus.m1_req & ~bus.m0_req;
`endif

  assign sel_we    = win ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = win ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = win ? bus.m1_wdata : bus.m0_wdata;

  always_comb begin
    state_nxt   = state;
    cur_we_nxt  = cur_we;
    cur_id_nxt  = cur_id;
    cnt_nxt     = cnt;
    gnt_nxt     = 2'b00;
    rvalid_nxt  = 2'b00;
    rdata0_nxt  = rdata0;
    rdata1_nxt  = rdata1;
    rd_addr_nxt = rd_addr;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    wr_en_nxt   = 1'b0;
`ifdef MEMORY_BUS_ARBITER_RR_EN
    prio_nxt    = prio;
`endif
    case (state)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          state_nxt    = ACCESS;
          cur_id_nxt   = win;
          cur_we_nxt   = sel_we;
          gnt_nxt[win] = 1'b1;
`ifdef MEMORY_BUS_ARBITER_RR_EN
          prio_nxt     = ~win;
`endif
          // Outputs are registered, so the access is set up on the edge that enters ACCESS.
          if (sel_we) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = sel_addr;
            wr_data_nxt = sel_wdata;
          end else begin
            rd_addr_nxt = sel_addr;
          end
        end
      end
      ACCESS: begin
        if (cur_we) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RWAIT;
          cnt_nxt   = 3'd0;
        end
      end
      RWAIT: begin
        if (cnt == 3'(RD_LAT - 1)) begin
          state_nxt          = IDLE;
          rvalid_nxt[cur_id] = 1'b1;
          if (cur_id) rdata1_nxt = bus.memory_read_data;
          else        rdata0_nxt = bus.memory_read_data;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_we  <= 1'b0;
      cur_id  <= 1'b0;
      cnt     <= 3'd0;
      gnt     <= 2'b00;
      rvalid  <= 2'b00;
      rdata0  <= '0;
      rdata1  <= '0;
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
`ifdef MEMORY_BUS_ARBITER_RR_EN
      prio    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cur_we  <= cur_we_nxt;
      cur_id  <= cur_id_nxt;
      cnt     <= cnt_nxt;
      gnt     <= gnt_nxt;
      rvalid  <= rvalid_nxt;
      rdata0  <= rdata0_nxt;
      rdata1  <= rdata1_nxt;
      rd_addr <= rd_addr_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
      wr_en   <= wr_en_nxt;
`ifdef MEMORY_BUS_ARBITER_RR_EN
      prio    <= prio_nxt;
`endif
    end
  end

  assign bus.m0_gnt               = gnt[0];
  assign bus.m1_gnt               = gnt[1];
  assign bus.m0_rvalid            = rvalid[0];
  assign bus.m1_rvalid            = rvalid[1];
  assign bus.m0_rdata             = rdata0;
  assign bus.m1_rdata             = rdata1;
  assign bus.memory_read_address  = rd_addr;
  assign bus.memory_write_address = wr_addr;
  assign bus.memory_write_data    = wr_data;
  assign bus.memory_write_enable  = wr_en;

endmodule
